// File: rtl/alu_ctrl_seq.sv
// Execute-stage ALU control decoder with an optional iterative RV32M
// multiply/divide sequencer that stalls the pipeline while it runs.
module alu_ctrl_seq #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          ENABLE_M = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [1:0]       aluop,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             valid_i,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       alucontrol,
    output logic             md_sel,
    output logic             stall,
    output logic             md_valid,
    output logic [WIDTH-1:0] md_result
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_PASB = 4'b1010;
    localparam logic [3:0] ALU_ILL  = 4'b1111;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc, lo, mb;
    logic [2:0]       f3;
    logic             res_neg;

    logic             m_op, is_md, start, abort, last_step;
    logic             signed_a, signed_b, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, div_ovf, special;
    logic [WIDTH-1:0] special_res;

    assign m_op   = (aluop == 2'b10) && (op == 7'b0110011) && (funct7 == 7'b0000001);
    assign is_md  = ENABLE_M && m_op;
    assign md_sel = is_md;

    // ALU operation select from instruction class and function fields
    always_comb begin
        alucontrol = ALU_ILL;
        unique case (aluop)
            2'b00: alucontrol = ALU_ADD;
            2'b01: alucontrol = ALU_SUB;
            2'b11: alucontrol = ALU_PASB;
            default: begin
                unique case (funct3)
                    3'b000:  alucontrol = (op[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alucontrol = ALU_SLL;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b011:  alucontrol = ALU_SLTU;
                    3'b100:  alucontrol = ALU_XOR;
                    3'b101:  alucontrol = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alucontrol = ALU_OR;
                    default: alucontrol = ALU_AND;
                endcase
            end
        endcase
        if (m_op) begin
            alucontrol = ALU_ILL;
        end
    end

    // Operand signedness, magnitudes and early-resolved divide cases
    assign signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
    assign signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign a_neg    = signed_a && src_a[WIDTH-1];
    assign b_neg    = signed_b && src_b[WIDTH-1];
    assign a_mag    = a_neg ? -src_a : src_a;
    assign b_mag    = b_neg ? -src_b : src_b;
    assign div_zero = funct3[2] && (src_b == '0);
    assign div_ovf  = funct3[2] && !funct3[0] && (src_a == MIN_NEG) && (src_b == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? src_a : '1;
        end else begin
            special_res = funct3[1] ? '0 : src_a;
        end
    end

    assign start     = (state == IDLE) && valid_i && is_md && !flush;
    assign abort     = !valid_i || flush;
    assign last_step = (count == CW'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        md_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = special ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last_step) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                md_valid  = valid_i && !flush;
            end
        endcase
        stall = valid_i && is_md && (state != DONE) && !flush;
    end

    // One radix-2 step: shift-add multiply or restoring divide
    logic [WIDTH:0]   mul_sum, div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] acc_step, lo_step;

    always_comb begin
        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, mb} : '0);
        div_shift = {acc, lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mb});
        if (f3[2]) begin
            acc_step = div_ge ? WIDTH'(div_shift - {1'b0, mb}) : div_shift[WIDTH-1:0];
            lo_step  = {lo[WIDTH-2:0], div_ge};
        end else begin
            acc_step = mul_sum[WIDTH:1];
            lo_step  = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up and result selection on the final step
    logic [PW-1:0]    prod, prod_fix;
    logic [WIDTH-1:0] div_sel, div_fix, final_res;

    always_comb begin
        prod      = {acc_step, lo_step};
        prod_fix  = res_neg ? -prod : prod;
        div_sel   = f3[1] ? acc_step : lo_step;
        div_fix   = res_neg ? -div_sel : div_sel;
        final_res = div_fix;
        if (!f3[2]) begin
            final_res = (f3[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[PW-1:WIDTH];
        end
    end

    // Sequencer datapath registers and result holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            acc       <= '0;
            lo        <= '0;
            mb        <= '0;
            f3        <= '0;
            res_neg   <= 1'b0;
            md_result <= '0;
        end else if (start) begin
            f3      <= funct3;
            res_neg <= (funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
            acc     <= '0;
            lo      <= a_mag;
            mb      <= b_mag;
            count   <= special ? '0 : CW'(WIDTH);
            if (special) begin
                md_result <= special_res;
            end
        end else if (state == BUSY) begin
            if (abort) begin
                count <= '0;
            end else begin
                acc   <= acc_step;
                lo    <= lo_step;
                count <= count - CW'(1);
                if (last_step) begin
                    md_result <= final_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode sweep plus scoreboarded M ops.
module tb_alu_ctrl_seq;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [6:0]   op;
    logic [1:0]   aluop;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic         valid_i, valid_nom, flush;
    logic [W-1:0] src_a, src_b;
    logic [3:0]   alucontrol, alucontrol_n;
    logic         md_sel, stall, md_valid;
    logic         md_sel_n, stall_n, md_valid_n;
    logic [W-1:0] md_result, md_result_n;

    alu_ctrl_seq #(.WIDTH(W), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .aluop(aluop), .funct3(funct3),
        .funct7(funct7), .valid_i(valid_i), .flush(flush), .src_a(src_a),
        .src_b(src_b), .alucontrol(alucontrol), .md_sel(md_sel), .stall(stall),
        .md_valid(md_valid), .md_result(md_result)
    );

    alu_ctrl_seq #(.WIDTH(W), .ENABLE_M(1'b0)) u_nom (
        .clk(clk), .rst_n(rst_n), .op(op), .aluop(aluop), .funct3(funct3),
        .funct7(funct7), .valid_i(valid_nom), .flush(flush), .src_a(src_a),
        .src_b(src_b), .alucontrol(alucontrol_n), .md_sel(md_sel_n), .stall(stall_n),
        .md_valid(md_valid_n), .md_result(md_result_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] val;
        int           due;
        string        name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;

    // Monitor: every md_valid pulse is matched against the scoreboard head
    always @(negedge clk) begin
        if (md_valid) begin
            tests++;
            if (prev_valid) begin
                fails++;
                $display("FAIL md_valid_consecutive: high in cycles %0d and %0d", cyc - 1, cyc);
            end else if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_md_valid: cycle %0d result %h, none expected", cyc, md_result);
            end else begin
                mon_e = sbq.pop_front();
                if (md_result !== mon_e.val || cyc != mon_e.due) begin
                    fails++;
                    $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                             mon_e.name, md_result, cyc, mon_e.val, mon_e.due);
                end
            end
        end
        prev_valid = md_valid;
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic dchk(input logic [6:0] o, input logic [1:0] a, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [3:0] exp, input string name);
        op = o; aluop = a; funct3 = f3; funct7 = f7; valid_i = 1'b0;
        #1;
        check(name, W'(alucontrol), W'(exp));
    endtask

    // Issue one M op at posedge+1; expected result goes to the scoreboard
    task automatic run_md(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int lat, input string name);
        int n_stall = 0;
        bit seen = 1'b0;
        op = 7'b0110011; aluop = 2'b10; funct7 = 7'b0000001; funct3 = f3;
        src_a = a; src_b = b; valid_i = 1'b1; flush = 1'b0;
        sbq.push_back('{exp, cyc + lat, name});
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (md_valid) seen = 1'b1;
            @(posedge clk);
            #1;
            if (k == 0) begin
                src_a = ~a;
                src_b = '0;
            end
        end
        valid_i = 1'b0;
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_timeout: no md_valid within 100 cycles", name);
        end
        check({name, "_stall"}, W'(n_stall), W'(lat));
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; valid_nom = 1'b0; flush = 1'b0;
        op = 7'b0110011; aluop = 2'b10; funct3 = 3'b000; funct7 = 7'b0000001;
        src_a = 32'd7; src_b = 32'd3;
        #3;
        check("reset_md_result", md_result, '0);
        check("reset_md_valid", W'(md_valid), '0);
        check("reset_stall", W'(stall), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Decode sweep
        dchk(7'b0110011, 2'b10, 3'b000, 7'b0000000, 4'b0000, "dec_add");
        dchk(7'b0110011, 2'b10, 3'b000, 7'b0100000, 4'b0001, "dec_sub");
        dchk(7'b0010011, 2'b10, 3'b000, 7'b0100000, 4'b0000, "dec_addi_imm10");
        dchk(7'b0010011, 2'b10, 3'b101, 7'b0100000, 4'b1001, "dec_srai");
        dchk(7'b0110011, 2'b10, 3'b101, 7'b0000000, 4'b1000, "dec_srl");
        dchk(7'b0110011, 2'b10, 3'b011, 7'b0000000, 4'b0110, "dec_sltu");
        dchk(7'b0110011, 2'b10, 3'b010, 7'b0000000, 4'b0101, "dec_slt");
        dchk(7'b0110011, 2'b10, 3'b001, 7'b0000000, 4'b0111, "dec_sll");
        dchk(7'b0110011, 2'b10, 3'b100, 7'b0000000, 4'b0100, "dec_xor");
        dchk(7'b0110011, 2'b10, 3'b110, 7'b0000000, 4'b0011, "dec_or");
        dchk(7'b0110011, 2'b10, 3'b111, 7'b0000000, 4'b0010, "dec_and");
        dchk(7'b0110111, 2'b11, 3'b000, 7'b0000000, 4'b1010, "dec_lui");
        dchk(7'b0000011, 2'b00, 3'b010, 7'b0100000, 4'b0000, "dec_mem");
        dchk(7'b1100011, 2'b01, 3'b000, 7'b0000000, 4'b0001, "dec_branch");

        // M op detection with and without the sequencer
        op = 7'b0110011; aluop = 2'b10; funct3 = 3'b000; funct7 = 7'b0000001;
        valid_i = 1'b0; valid_nom = 1'b1;
        #1;
        check("md_sel_mul", W'(md_sel), W'(1));
        check("nom_alucontrol", W'(alucontrol_n), W'(4'b1111));
        check("nom_md_sel", W'(md_sel_n), '0);
        check("nom_stall", W'(stall_n), '0);
        @(posedge clk);
        #1;
        check("nom_md_valid", W'(md_valid_n), '0);
        check("nom_stall_next", W'(stall_n), '0);
        valid_nom = 1'b0;

        // Multiply
        run_md(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7x-3");
        run_md(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max");
        run_md(3'b001, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 33, "mulh_min_x2");
        run_md(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_-1");

        // Divide / remainder
        run_md(3'b100, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 33, "div_-20_6");
        run_md(3'b110, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 33, "rem_-20_6");
        run_md(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
        run_md(3'b111, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");

        // Flush at S+10 of a div, then a mul issued the next cycle
        op = 7'b0110011; aluop = 2'b10; funct7 = 7'b0000001; funct3 = 3'b100;
        src_a = 32'hFFFF_FFEC; src_b = 32'd6; valid_i = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        #1;
        check("flush_stall_low", W'(stall), '0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_md_result_held", md_result, 32'd2);
        run_md(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_after_flush");

        // Asynchronous reset in the middle of a BUSY multiply
        op = 7'b0110011; aluop = 2'b10; funct7 = 7'b0000001; funct3 = 3'b011;
        src_a = 32'd1234; src_b = 32'd5678; valid_i = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        valid_i = 1'b0;
        #1;
        check("async_rst_md_result", md_result, '0);
        check("async_rst_md_valid", W'(md_valid), '0);
        check("async_rst_stall", W'(stall), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_md(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu_after_reset");

        // Early-resolved divide cases
        run_md(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by_zero");
        run_md(3'b110, 32'd5, 32'd0, 32'd5, 1, "rem_by_zero");
        run_md(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by_zero");
        run_md(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_overflow");
        run_md(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_overflow");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", W'(sbq.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
